// File: rtl/func_eval_arbiter.sv
// func_eval_arbiter: round-robin front end for the shared 5-input function unit.
// Registers the winning operand onto fu_i, samples fu_r one cycle later and
// returns the bit to the winning client over its response handshake.
// Optional result cache: define FEA_CACHE_EN to add a 32-entry truth-table cache.
module func_eval_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_bit,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [4:0]        fu_i,
    input  logic              fu_r,
    input  logic              cache_clr,
    output logic              busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   owner_q, owner_d;
    logic [GW-1:0]   lastGrant_q, lastGrant_d;
    logic [4:0]      fuOp_q, fuOp_d;
    logic            rspBit_q, rspBit_d;

    logic            found;
    logic [GW-1:0]   winner;
    logic [4:0]      winOp;
    logic            cacheHit;
    logic            cacheBit;

    // Round-robin pick: first requester above lastGrant, else wrap to the lowest one.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k] && (k > int'(lastGrant_q))) begin
                found  = 1'b1;
                winner = GW'(k);
            end
        end
        if (!found) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k] && (k <= int'(lastGrant_q))) begin
                    found  = 1'b1;
                    winner = GW'(k);
                end
            end
        end
        winOp = req_data[int'(winner) * 5 +: 5];
    end

`ifdef FEA_CACHE_EN
    logic [31:0] cacheBits_q;
    logic [31:0] cacheVld_q;

    assign cacheHit = found && cacheVld_q[winOp];
    assign cacheBit = cacheBits_q[winOp];

    // Fill the entry for the evaluated operand; a same-cycle clear overrides the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cacheBits_q <= '0;
            cacheVld_q  <= '0;
        end else begin
            if (state_q == EVAL) begin
                cacheBits_q[fuOp_q] <= fu_r;
                cacheVld_q[fuOp_q]  <= 1'b1;
            end
            if (cache_clr) begin
                cacheVld_q <= '0;
            end
        end
    end
`else
    logic unused_cacheClr;

    assign cacheHit        = 1'b0;
    assign cacheBit        = 1'b0;
    assign unused_cacheClr = cache_clr;
`endif

    // Next-state and handshake outputs for the IDLE/EVAL/RESP sequence.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        fuOp_d      = fuOp_q;
        rspBit_d    = rspBit_q;
        req_ready   = '0;
        rsp_valid   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    owner_d           = winner;
                    fuOp_d            = winOp;
                    if (cacheHit) begin
                        rspBit_d = cacheBit;
                        state_d  = RESP;
                    end else begin
                        state_d  = EVAL;
                    end
                end
            end
            EVAL: begin
                rspBit_d = fu_r;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    lastGrant_d = owner_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastGrant_q <= GW'(NREQ - 1);
            fuOp_q      <= '0;
            rspBit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            fuOp_q      <= fuOp_d;
            rspBit_q    <= rspBit_d;
        end
    end

    assign fu_i    = fuOp_q;
    assign rsp_bit = rspBit_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_func_eval_arbiter.sv
// Testbench for func_eval_arbiter: directed requests, expected responses queued
// by the stimulus and checked by a separate response monitor.
module tb_func_eval_arbiter;

    localparam int NREQ = 4;
`ifdef FEA_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  reqValid;
    logic [19:0] reqData;
    logic [3:0]  reqReady;
    logic [3:0]  rspValid;
    logic        rspBit;
    logic [3:0]  rspReady;
    logic [4:0]  fuI;
    logic        fuR;
    logic        cacheClr;
    logic        busy;

    typedef struct {
        int   client;
        logic bitv;
        int   lat;
    } exp_t;

    exp_t sbQ[$];
    int   acceptQ[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prevRsp = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural function unit: odd parity of the 5-bit operand.
    assign fuR = ^fuI;

    func_eval_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_ready (reqReady),
        .rsp_valid (rspValid),
        .rsp_bit   (rspBit),
        .rsp_ready (rspReady),
        .fu_i      (fuI),
        .fu_r      (fuR),
        .cache_clr (cacheClr),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int client, input logic bitv, input int lat);
        exp_t e;
        e.client = client;
        e.bitv   = bitv;
        e.lat    = lat;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] valid);
        @(posedge clk);
        #1;
        reqValid = valid;
    endtask

    task automatic waitGrant(input int k, output time t);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|reqReady) break;
        end
        checkOutput($sformatf("grant_%0d", k), {28'b0, reqReady}, 32'(1 << k));
        t = $time;
    endtask

    task automatic dropAfterAccept();
        @(posedge clk);
        #1;
        reqValid = 4'b0000;
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (sbQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", 32'(sbQ.size()), 32'd0);
    endtask

    // Response monitor: on each new response pop the scoreboard and compare.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   a;
        cyc++;
        if (!rstN) begin
            acceptQ.delete();
            prevRsp = 1'b0;
        end else begin
            if ((|rspValid) && !prevRsp) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_rsp", {28'b0, rspValid}, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rsp_client", {28'b0, rspValid}, 32'(1 << e.client));
                    checkOutput("rsp_bit", {31'b0, rspBit}, {31'b0, e.bitv});
                    if (acceptQ.size() > 0) begin
                        a = acceptQ.pop_front();
                        checkOutput("rsp_latency", 32'(cyc - a), 32'(e.lat));
                    end else begin
                        checkOutput("rsp_no_accept", 32'd0, 32'd1);
                    end
                end
            end
            prevRsp = |rspValid;
            if (|(reqReady & reqValid)) acceptQ.push_back(cyc);
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit");
    end

    // Directed test sequence.
    initial begin
        time t;
        time prevT;
        rstN     = 1'b0;
        reqValid = 4'b0000;
        reqData  = {5'b11001, 5'b00111, 5'b00011, 5'b00001};
        rspReady = 4'b1111;
        cacheClr = 1'b0;
        prevT    = 0;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {28'b0, reqReady}, 32'd0);
        checkOutput("rst_rsp_valid", {28'b0, rspValid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_fu_i", {27'b0, fuI}, 32'd0);
        checkOutput("rst_rsp_bit", {31'b0, rspBit}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("post_rst_fu_i", {27'b0, fuI}, 32'd0);

        $display("[TB] continuous round robin");
        pushExp(0, 1'b1, 2);
        pushExp(1, 1'b0, 2);
        pushExp(2, 1'b1, 2);
        pushExp(3, 1'b1, 2);
        pushExp(0, 1'b1, HIT_LAT);
        applyStimulus(4'b1111);
        for (int n = 0; n < 5; n++) begin
            waitGrant(n % 4, t);
            if (n > 0) checkOutput("grant_gap", 32'((t - prevT) / 10), 32'd3);
            prevT = t;
        end
        dropAfterAccept();
        drain();

        $display("[TB] single request client 2");
        reqData[14:10] = 5'b10110;
        pushExp(2, 1'b1, 2);
        applyStimulus(4'b0100);
        waitGrant(2, t);
        dropAfterAccept();
        @(negedge clk);
        checkOutput("eval_fu_i", {27'b0, fuI}, 32'h16);
        checkOutput("eval_busy", {31'b0, busy}, 32'd1);
        checkOutput("eval_rsp_valid", {28'b0, rspValid}, 32'd0);
        drain();

        $display("[TB] response stall on client 1");
        reqData[9:5] = 5'b01101;
        pushExp(1, 1'b1, 2);
        applyStimulus(4'b0010);
        waitGrant(1, t);
        @(posedge clk);
        #1;
        reqValid       = 4'b1101;
        reqData[14:10] = 5'b11110;
        rspReady       = 4'b1101;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_req_ready", {28'b0, reqReady}, 32'd0);
            checkOutput("stall_rsp_valid", {28'b0, rspValid}, 32'h2);
            checkOutput("stall_busy", {31'b0, busy}, 32'd1);
        end
        pushExp(2, 1'b0, 2);
        @(posedge clk);
        #1;
        rspReady = 4'b1111;
        waitGrant(2, t);
        dropAfterAccept();
        drain();

        $display("[TB] reset during evaluation");
        applyStimulus(4'b1000);
        waitGrant(3, t);
        dropAfterAccept();
        checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
        checkOutput("abort_fu_i_before", {27'b0, fuI}, 32'h19);
        rstN = 1'b0;
        #1;
        checkOutput("abort_fu_i", {27'b0, fuI}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_rsp_valid", {28'b0, rspValid}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        pushExp(0, 1'b1, 2);
        applyStimulus(4'b1111);
        waitGrant(0, t);
        dropAfterAccept();
        drain();

        $display("[TB] repeated operand and cache clear");
        reqData[9:5] = 5'b00011;
        pushExp(1, 1'b0, 2);
        applyStimulus(4'b0010);
        waitGrant(1, t);
        dropAfterAccept();
        drain();
        pushExp(1, 1'b0, HIT_LAT);
        applyStimulus(4'b0010);
        waitGrant(1, t);
        dropAfterAccept();
        drain();
        @(posedge clk);
        #1;
        cacheClr = 1'b1;
        @(posedge clk);
        #1;
        cacheClr = 1'b0;
        pushExp(1, 1'b0, 2);
        applyStimulus(4'b0010);
        waitGrant(1, t);
        dropAfterAccept();
        drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/func_eval_arbiter.md
# func_eval_arbiter

Sequential front end for the shared 5-input Boolean function unit (the 2-to-4 decoder / 8-to-1 mux datapath). Accepts evaluation requests from up to NREQ clients over valid/ready handshakes and grants the single function unit round-robin. It registers the selected 5-bit operand onto the unit's input, samples the combinational result one cycle later and returns it to the winning client over a per-client response handshake.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..8
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  NREQ  client k has an operand pending
- `req_data`  in  5*NREQ  client k operand in bits [5k+4:5k]; held stable while `req_valid[k]` is high
- `req_ready`  out  NREQ  one-hot accept strobe
- `rsp_valid`  out  NREQ  one-hot; result available for client k
- `rsp_bit`  out  1  result bit; meaningful only while any `rsp_valid` is high
- `rsp_ready`  in  NREQ  client k consumes its result
- `fu_i`  out  5  registered operand driving the function unit input `i`
- `fu_r`  in  1  combinational result `r` from the function unit
- `cache_clr`  in  1  invalidates the result cache; ignored when the cache is compiled out
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE: if any `req_valid` is high, pick winner k by round-robin starting at `last_grant+1` (mod NREQ). Assert `req_ready[k]` combinationally in the same cycle. On that edge: `fu_i <= req_data[k]`, `owner <= k`, go to EVAL. No request: stay in IDLE, all `req_ready` low.
- EVAL: `fu_i` is stable for the whole cycle. At the end of the cycle, `rsp_bit <= fu_r`, then go to RESP.
- RESP: `rsp_valid[owner]` is high and `rsp_bit` is held. When `rsp_ready[owner]` is high: `last_grant <= owner`, go to IDLE. `rsp_ready` from non-owners is ignored.
- `req_ready` is only ever asserted in IDLE, so at most one transaction is in flight.
- `fu_i` keeps its last value in IDLE and RESP.
- A client dropping `req_valid` before it is granted is legal; that client loses nothing.
- Reset values: state IDLE, `fu_i` 5'b00000, `rsp_bit` 0, `rsp_valid` all 0, `req_ready` all 0, `busy` 0. `last_grant` resets to NREQ-1, so client 0 has first priority.
- A reset in any state aborts the transaction. No response is delivered.

## Timing
- Accept at edge T (`req_valid[k]` and `req_ready[k]`). EVAL runs during cycle T+1. `rsp_valid[k]` rises at T+2.
- Minimum of 3 cycles per transaction, accept to accept, when `rsp_ready` is held high.
- The combinational path `fu_i` to `fu_r` has one full cycle; `fu_r` is never sampled in the same cycle `fu_i` changes.
- `rsp_ready` held low: stays in RESP indefinitely and grants nothing new.

## Configuration
- `FEA_CACHE_EN` defined:
  - Adds a 32-entry truth-table cache (32 result bits plus 32 valid bits), indexed by operand.
  - Cache hit in IDLE: `rsp_bit <= cache[op]` and go straight to RESP, so `rsp_valid` rises at T+1.
  - Cache miss: normal path, and the entry is filled at the end of EVAL.
  - `cache_clr` clears all valid bits at the next edge. A clear in the same cycle as a fill wins, leaving the entry invalid.
  - Reset clears all valid bits.
- `FEA_CACHE_EN` undefined:
  - No cache storage; every request goes through EVAL.
  - `cache_clr` is ignored.

## Test plan
- Reset: hold `rst_n` low, then release. All outputs at their reset values, `busy` 0, `fu_i` 00000.
- Single request, `req_data[2]` = 5'b10110 with a behavioural model on `fu_r`. `req_ready` = 0100 in cycle T, `fu_i` = 10110 during T+1, `rsp_valid` = 0100 at T+2, and `rsp_bit` matches the model.
- All four clients request continuously with `rsp_ready` tied high. Grant order is 0,1,2,3,0, spaced 3 cycles apart.
- Client 1 granted, `rsp_ready[1]` held low for 5 cycles while the other clients request. FSM stays in RESP and `req_ready` stays 0000. After `rsp_ready[1]` goes high, the next grant goes to client 2.
- Assert `rst_n` during EVAL. Outputs clear asynchronously, no `rsp_valid` appears, and the next grant goes to client 0.
- Cache: with `FEA_CACHE_EN`, request operand 5'b00011 twice. The first response arrives at T+2, the second at T+1. After `cache_clr`, the next request for it takes T+2 again. Without the macro, every request takes T+2.
